// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl: sequencing control for the 5-stage RV32i pipeline.
// It keeps a small rd/we scoreboard for the exec, mem and write-back stages.
// From that scoreboard it detects RAW hazards against the decode instruction.
// It also drives stall, bubble, fetch squash and the PC-next source select.
// Branches are predicted not-taken and are resolved during their exec cycle.
module rv32i_hazard_ctrl #(
    parameter bit         WB_BYPASS     = 1'b1,
    parameter logic [2:0] SEL_PC_PLUS_4 = 3'd0,
    parameter logic [2:0] SEL_PC_JAL    = 3'd1,
    parameter logic [2:0] SEL_PC_JALR   = 3'd2,
    parameter logic [2:0] SEL_PC_BRANCH = 3'd3
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [4:0] dec_rs1_add_i,
    input  logic [4:0] dec_rs2_add_i,
    input  logic       dec_rs1_used_i,
    input  logic       dec_rs2_used_i,
    input  logic [4:0] dec_rd_add_i,
    input  logic       dec_reg_we_i,
    input  logic       dec_is_jal_i,
    input  logic       dec_is_jalr_i,
    input  logic       dec_is_branch_i,
    input  logic       br_taken_i,
    output logic       stall_o,
    output logic       bubble_o,
    output logic       fetch_jump_o,
    output logic [2:0] pc_next_sel_o,
    output logic [4:0] wb_rd_add_o,
    output logic       wb_we_o
);

    typedef enum logic {
        RUN        = 1'b0,
        BR_RESOLVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic       ex_we_q, mem_we_q, wb_we_q;
    logic       hit_ex, hit_mem, hit_wb, hazard;

    // An in-flight writer conflicts only if it really writes a nonzero rd that
    // the decode instruction actually reads. x0 is never a hazard source.
    function automatic logic entry_hits(input logic       we,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic       rs1_used,
                                        input logic [4:0] rs2,
                                        input logic       rs2_used);
        return we && (rd != 5'd0) &&
               ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));
    endfunction

    assign hit_ex  = entry_hits(ex_we_q, ex_rd_q, dec_rs1_add_i, dec_rs1_used_i,
                                dec_rs2_add_i, dec_rs2_used_i);
    assign hit_mem = entry_hits(mem_we_q, mem_rd_q, dec_rs1_add_i, dec_rs1_used_i,
                                dec_rs2_add_i, dec_rs2_used_i);
    assign hit_wb  = entry_hits(wb_we_q, wb_rd_q, dec_rs1_add_i, dec_rs1_used_i,
                                dec_rs2_add_i, dec_rs2_used_i);

    // A write-through regfile already forwards the WB value, so WB is skipped then.
    assign hazard = hit_ex || hit_mem || (!WB_BYPASS && hit_wb);

    assign wb_rd_add_o = wb_rd_q;
    assign wb_we_o     = wb_we_q;

    // Decode-time control: a taken branch in exec wins, then hazard, then jumps.
    always_comb begin
        stall_o       = 1'b0;
        bubble_o      = 1'b0;
        fetch_jump_o  = 1'b0;
        pc_next_sel_o = SEL_PC_PLUS_4;
        state_d       = RUN;
        if ((state_q == BR_RESOLVE) && br_taken_i) begin
            // The decode instruction is on the wrong path, so it is turned into a bubble.
            pc_next_sel_o = SEL_PC_BRANCH;
            fetch_jump_o  = 1'b1;
            bubble_o      = 1'b1;
        end else if (hazard) begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
        end else if (dec_is_jal_i) begin
            pc_next_sel_o = SEL_PC_JAL;
            fetch_jump_o  = 1'b1;
        end else if (dec_is_jalr_i) begin
            pc_next_sel_o = SEL_PC_JALR;
            fetch_jump_o  = 1'b1;
        end else if (dec_is_branch_i) begin
            state_d = BR_RESOLVE;
        end
    end

    // FSM state plus the rd/we scoreboard that advances every cycle.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= RUN;
            ex_rd_q  <= 5'd0;
            ex_we_q  <= 1'b0;
            mem_rd_q <= 5'd0;
            mem_we_q <= 1'b0;
            wb_rd_q  <= 5'd0;
            wb_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ex_rd_q  <= bubble_o ? 5'd0 : dec_rd_add_i;
            ex_we_q  <= bubble_o ? 1'b0 : dec_reg_we_i;
            mem_rd_q <= ex_rd_q;
            mem_we_q <= ex_we_q;
            wb_rd_q  <= mem_rd_q;
            wb_we_q  <= mem_we_q;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Testbench for rv32i_hazard_ctrl. Two instances share the same decode stream.
// One instance is built with WB_BYPASS=1 and the other with WB_BYPASS=0.
// A reference model tracks in-flight writers as an age-ordered list per instance.
// Each model also keeps a "branch awaiting resolution" flag.
module tb_rv32i_hazard_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, jal, jalr, br, tk;

    logic       st_a, bb_a, fj_a, wbwe_a;
    logic [2:0] sel_a;
    logic [4:0] wbrd_a;
    logic       st_b, bb_b, fj_b, wbwe_b;
    logic [2:0] sel_b;
    logic [4:0] wbrd_b;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    // Model state. Index 0 is the WB_BYPASS=1 instance, index 1 is WB_BYPASS=0.
    // Age index 0 is the youngest in-flight writer (exec), index 2 the oldest (wb).
    logic [4:0] m_rd[2][3];
    logic       m_we[2][3];
    logic       m_br[2];

    always #5 clk = ~clk;

    rv32i_hazard_ctrl #(.WB_BYPASS(1'b1)) u_dut_a (
        .clk_i(clk), .resetn_i(resetn),
        .dec_rs1_add_i(rs1), .dec_rs2_add_i(rs2),
        .dec_rs1_used_i(u1), .dec_rs2_used_i(u2),
        .dec_rd_add_i(rd), .dec_reg_we_i(we),
        .dec_is_jal_i(jal), .dec_is_jalr_i(jalr), .dec_is_branch_i(br),
        .br_taken_i(tk),
        .stall_o(st_a), .bubble_o(bb_a), .fetch_jump_o(fj_a),
        .pc_next_sel_o(sel_a), .wb_rd_add_o(wbrd_a), .wb_we_o(wbwe_a)
    );

    rv32i_hazard_ctrl #(.WB_BYPASS(1'b0)) u_dut_b (
        .clk_i(clk), .resetn_i(resetn),
        .dec_rs1_add_i(rs1), .dec_rs2_add_i(rs2),
        .dec_rs1_used_i(u1), .dec_rs2_used_i(u2),
        .dec_rd_add_i(rd), .dec_reg_we_i(we),
        .dec_is_jal_i(jal), .dec_is_jalr_i(jalr), .dec_is_branch_i(br),
        .br_taken_i(tk),
        .stall_o(st_b), .bubble_o(bb_b), .fetch_jump_o(fj_b),
        .pc_next_sel_o(sel_b), .wb_rd_add_o(wbrd_b), .wb_we_o(wbwe_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {stall, bubble, fetch_jump, sel} for instance k.
    function automatic logic [5:0] model_out(input int k);
        logic hz;
        int   depth;
        hz    = 1'b0;
        depth = (k == 0) ? 2 : 3;
        for (int s = 0; s < depth; s++) begin
            if (m_we[k][s] && (m_rd[k][s] != 5'd0) &&
                ((u1 && (m_rd[k][s] == rs1)) || (u2 && (m_rd[k][s] == rs2))))
                hz = 1'b1;
        end
        if (m_br[k] && tk) return {3'b011, 3'd3};
        if (hz)            return {3'b110, 3'd0};
        if (jal)           return {3'b001, 3'd1};
        if (jalr)          return {3'b001, 3'd2};
        return 6'd0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic [5:0] o;
        logic       nb;
        if (!resetn) begin
            for (int k = 0; k < 2; k++) begin
                m_br[k] = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    m_rd[k][s] = 5'd0;
                    m_we[k][s] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                o  = model_out(k);
                nb = !(m_br[k] && tk) && !o[5] && br;
                m_rd[k][2] = m_rd[k][1];
                m_we[k][2] = m_we[k][1];
                m_rd[k][1] = m_rd[k][0];
                m_we[k][1] = m_we[k][0];
                m_rd[k][0] = o[4] ? 5'd0 : rd;
                m_we[k][0] = o[4] ? 1'b0 : we;
                m_br[k]    = nb;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0] oa, ob;
        if (started) begin
            oa = model_out(0);
            ob = model_out(1);
            chk("a.stall",  32'(st_a),   32'(oa[5]));
            chk("a.bubble", 32'(bb_a),   32'(oa[4]));
            chk("a.fjump",  32'(fj_a),   32'(oa[3]));
            chk("a.sel",    32'(sel_a),  32'(oa[2:0]));
            chk("a.wb_rd",  32'(wbrd_a), 32'(m_rd[0][2]));
            chk("a.wb_we",  32'(wbwe_a), 32'(m_we[0][2]));
            chk("b.stall",  32'(st_b),   32'(ob[5]));
            chk("b.bubble", 32'(bb_b),   32'(ob[4]));
            chk("b.fjump",  32'(fj_b),   32'(ob[3]));
            chk("b.sel",    32'(sel_b),  32'(ob[2:0]));
            chk("b.wb_rd",  32'(wbrd_b), 32'(m_rd[1][2]));
            chk("b.wb_we",  32'(wbwe_b), 32'(m_we[1][2]));
        end
    end

    task automatic drive(input logic [4:0] d_rd, input logic d_we,
                         input logic [4:0] d_rs1, input logic d_u1,
                         input logic [4:0] d_rs2, input logic d_u2,
                         input logic d_jal, input logic d_jalr,
                         input logic d_br, input logic d_tk);
        @(posedge clk);
        #1;
        rd = d_rd; we = d_we; rs1 = d_rs1; u1 = d_u1; rs2 = d_rs2; u2 = d_u2;
        jal = d_jal; jalr = d_jalr; br = d_br; tk = d_tk;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt_a, cnt_b;
        bit  released;
        resetn = 1'b0;
        rd = 0; we = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0;
        jal = 0; jalr = 0; br = 0; tk = 0;
        started = 1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst.stall",  32'(st_a),   32'd0);
        chk("rst.wb_we",  32'(wbwe_a), 32'd0);
        chk("rst.wb_rd",  32'(wbrd_b), 32'd0);

        // addi x5,x0,1 ; add x6,x5,x5 (held in decode while stalled)
        drive(5'd5, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 4; i++) begin
            drive(5'd6, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cnt_a += int'(st_a);
            cnt_b += int'(st_b);
            if (i == 2) begin
                chk("raw.a.wb_we", 32'(wbwe_a), 32'd1);
                chk("raw.a.wb_rd", 32'(wbrd_a), 32'd5);
                chk("raw.b.wb_rd", 32'(wbrd_b), 32'd5);
            end
        end
        chk("raw.a.stall_cycles", 32'(cnt_a), 32'd2);
        chk("raw.b.stall_cycles", 32'(cnt_b), 32'd3);
        nop(3);

        // Writer to x0, then reader of x0
        drive(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd8, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("x0.a.stall", 32'(st_a), 32'd0);
        chk("x0.b.stall", 32'(st_b), 32'd0);
        nop(3);

        // JAL without hazard
        drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jal.sel",   32'(sel_a), 32'd1);
        chk("jal.fjump", 32'(fj_a),  32'd1);
        chk("jal.stall", 32'(st_b),  32'd0);
        nop(3);

        // JALR waiting on x7
        drive(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("jalr.first_stall", 32'(st_a), 32'd1);
        chk("jalr.first_sel",   32'(sel_a), 32'd0);
        released = 0;
        for (int i = 0; i < 6 && !released; i++) begin
            drive(5'd1, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (!st_a) begin
                released = 1;
                chk("jalr.sel",   32'(sel_a), 32'd2);
                chk("jalr.fjump", 32'(fj_a),  32'd1);
            end
        end
        chk("jalr.release", 32'(released), 32'd1);
        nop(4);

        // Taken branch squashes the wrong-path instruction that writes x9
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("br.predict_sel", 32'(sel_a), 32'd0);
        chk("br.predict_fj",  32'(fj_a),  32'd0);
        drive(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("brt.sel",    32'(sel_a), 32'd3);
        chk("brt.fjump",  32'(fj_a),  32'd1);
        chk("brt.bubble", 32'(bb_a),  32'd1);
        chk("brt.stall",  32'(st_a),  32'd0);
        chk("brt.b.sel",  32'(sel_b), 32'd3);
        for (int i = 0; i < 4; i++) begin
            nop(1);
            chk("brt.a.squashed_wb", 32'(wbwe_a && (wbrd_a == 5'd9)), 32'd0);
            chk("brt.b.squashed_wb", 32'(wbwe_b && (wbrd_b == 5'd9)), 32'd0);
        end

        // Not-taken branch followed by a second branch
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("brnt.bubble", 32'(bb_a),  32'd0);
        chk("brnt.sel",    32'(sel_a), 32'd0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("br2.sel",   32'(sel_a), 32'd3);
        chk("br2.fjump", 32'(fj_a),  32'd1);
        nop(2);

        // Reset while a branch is resolving and the scoreboard is populated
        drive(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rd = 0; we = 0; rs1 = 5'd4; u1 = 1; rs2 = 0; u2 = 0;
        jal = 0; jalr = 0; br = 0; tk = 1;
        #1;
        chk("pre_rst.wb_we", 32'(wbwe_a), 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst.a.wb_we", 32'(wbwe_a), 32'd0);
        chk("mid_rst.a.wb_rd", 32'(wbrd_a), 32'd0);
        chk("mid_rst.a.stall", 32'(st_a),   32'd0);
        chk("mid_rst.a.sel",   32'(sel_a),  32'd0);
        chk("mid_rst.b.wb_we", 32'(wbwe_b), 32'd0);
        chk("mid_rst.b.stall", 32'(st_b),   32'd0);
        resetn = 1'b1;
        @(negedge clk);
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst.sel",   32'(sel_a), 32'd0);
        chk("post_rst.fjump", 32'(fj_a),  32'd0);
        nop(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
